// File: rtl/wb_dma_arbiter_pkg.sv
// Shared definitions for the Wishbone DMA bus arbiter: ownership states,
// common bus widths and a small index-width helper.
package wb_dma_arbiter_pkg;

  localparam int ADR_W = 16;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;

  // Bus ownership phases; T2D and T2C are the idle turnaround cycles
  typedef enum logic [1:0] {
    OWN_CPU = 2'd0,
    T2D     = 2'd1,
    OWN_DMA = 2'd2,
    T2C     = 2'd3
  } arb_state_t;

  // Width of an index into n masters, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_dma_arbiter_if.sv
// Signal bundle between the processor, the DMA masters, the common bus and
// the arbiter. The arbiter uses the master modport (it drives the common
// bus); the surrounding system uses the slave modport.
interface wb_dma_arbiter_if #(parameter int NDMA = 2);
  import wb_dma_arbiter_pkg::*;

  logic [ADR_W-1:0]      cpu_adr_i;
  logic [DAT_W-1:0]      cpu_dat_i;
  logic                  cpu_we_i;
  logic [SEL_W-1:0]      cpu_sel_i;
  logic                  cpu_stb_i;
  logic                  cpu_ack_o;
  logic                  cpu_gnt_o;

  logic [NDMA-1:0]       dma_req_i;
  logic [NDMA-1:0]       dma_gnt_o;
  logic [ADR_W*NDMA-1:0] dma_adr_i;
  logic [DAT_W*NDMA-1:0] dma_dat_i;
  logic [NDMA-1:0]       dma_we_i;
  logic [SEL_W*NDMA-1:0] dma_sel_i;
  logic [NDMA-1:0]       dma_stb_i;
  logic [NDMA-1:0]       dma_ack_o;

  logic [ADR_W-1:0]      bus_adr_o;
  logic [DAT_W-1:0]      bus_dat_o;
  logic                  bus_we_o;
  logic [SEL_W-1:0]      bus_sel_o;
  logic                  bus_stb_o;
  logic                  bus_cyc_o;
  logic                  bus_ack_i;
  logic                  dma_active_o;

  modport master (
    input  cpu_adr_i, cpu_dat_i, cpu_we_i, cpu_sel_i, cpu_stb_i,
    output cpu_ack_o, cpu_gnt_o,
    input  dma_req_i, dma_adr_i, dma_dat_i, dma_we_i, dma_sel_i, dma_stb_i,
    output dma_gnt_o, dma_ack_o,
    output bus_adr_o, bus_dat_o, bus_we_o, bus_sel_o, bus_stb_o, bus_cyc_o,
    input  bus_ack_i,
    output dma_active_o
  );

  modport slave (
    output cpu_adr_i, cpu_dat_i, cpu_we_i, cpu_sel_i, cpu_stb_i,
    input  cpu_ack_o, cpu_gnt_o,
    output dma_req_i, dma_adr_i, dma_dat_i, dma_we_i, dma_sel_i, dma_stb_i,
    input  dma_gnt_o, dma_ack_o,
    input  bus_adr_o, bus_dat_o, bus_we_o, bus_sel_o, bus_stb_o, bus_cyc_o,
    output bus_ack_i,
    input  dma_active_o
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Round-robin picker: starting just after the last winner, returns the first
// requesting DMA master as a one-hot vector and as an index.
module wb_rr_pick
  import wb_dma_arbiter_pkg::*;
#(
  parameter  int NDMA  = 2,
  localparam int IDX_W = idx_width(NDMA)
) (
  input  logic [NDMA-1:0]  req,
  input  logic [IDX_W-1:0] rr,
  output logic [NDMA-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan rr+1, rr+2, ... (mod NDMA) so the previous winner is checked last
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 1; k <= NDMA; k++) begin
      if (!any && req[(int'(rr) + k) % NDMA]) begin
        any = 1'b1;
        idx = IDX_W'((int'(rr) + k) % NDMA);
        onehot[(int'(rr) + k) % NDMA] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_dma_arbiter.sv
// Bus-ownership controller sharing the system Wishbone bus between the
// processor and NDMA DMA masters. DMA masters rotate round-robin, each
// tenure is bounded by HOLD_MAX cycles, and the processor is given a slot
// (one transfer or CPU_SLOT idle cycles) between DMA tenures.
module wb_dma_arbiter
  import wb_dma_arbiter_pkg::*;
#(
  parameter int NDMA     = 2,
  parameter int HOLD_MAX = 64,
  parameter int CPU_SLOT = 16
) (
  input logic             clk_p,
  input logic             rst_n,
  wb_dma_arbiter_if.master bus
);

  localparam int IDX_W  = idx_width(NDMA);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam int SLOT_W = (CPU_SLOT > 1) ? $clog2(CPU_SLOT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);
  // slot_cnt value whose increment reaches CPU_SLOT-1
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'((CPU_SLOT >= 2) ? CPU_SLOT - 2 : 0);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic               cpu_gnt_q;
  logic [NDMA-1:0]    dma_gnt_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               slot_ok;
  logic [SLOT_W-1:0]  slot_cnt;

  logic [NDMA-1:0]    pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               owner_req;
  logic               owner_stb;

  wb_rr_pick #(.NDMA(NDMA)) u_pick (
    .req    (bus.dma_req_i),
    .rr     (rr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign owner_req = bus.dma_req_i[owner_q];
  assign owner_stb = bus.dma_stb_i[owner_q];

  // Ownership state register
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) state_q <= OWN_CPU;
    else        state_q <= state_d;
  end

  // Ownership transitions; a strobe in progress always blocks a handover
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OWN_CPU: if ((|bus.dma_req_i) && !bus.cpu_stb_i && slot_ok) state_d = T2D;
      T2D:     state_d = pick_any ? OWN_DMA : OWN_CPU;
      OWN_DMA: if (!owner_stb && (!owner_req || hold_cnt == HOLD_LIMIT)) state_d = T2C;
      T2C:     state_d = OWN_CPU;
      default: state_d = OWN_CPU;
    endcase
  end

  // Registered grants, derived from the upcoming ownership state
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      cpu_gnt_q <= 1'b1;
      dma_gnt_q <= '0;
    end else begin
      cpu_gnt_q <= (state_d == OWN_CPU);
      if (state_q == T2D && state_d == OWN_DMA) dma_gnt_q <= pick_onehot;
      else if (state_d != OWN_DMA)              dma_gnt_q <= '0;
    end
  end

  // Owner, rotation pointer and tenure length; hold_cnt counts the owned cycle in progress
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= '0;
      rr_q     <= IDX_W'(NDMA - 1);
      hold_cnt <= '0;
    end else if (state_q == T2D && pick_any) begin
      owner_q  <= pick_idx;
      rr_q     <= pick_idx;
      hold_cnt <= HOLD_W'(1);
    end else if (state_q == OWN_DMA && hold_cnt != HOLD_LIMIT) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Processor slot: closed on return from DMA, reopened by one transfer or a timeout
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      slot_ok  <= 1'b1;
      slot_cnt <= '0;
    end else if (state_q == T2C) begin
      slot_ok  <= (CPU_SLOT <= 1);
      slot_cnt <= '0;
    end else if (state_q == OWN_CPU && !slot_ok) begin
      if ((bus.cpu_stb_i && bus.bus_ack_i) || slot_cnt == SLOT_LAST) slot_ok <= 1'b1;
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // Common bus multiplexer driven by the registered owner; idle in turnaround
  always_comb begin
    bus.bus_adr_o = '0;
    bus.bus_dat_o = '0;
    bus.bus_we_o  = 1'b0;
    bus.bus_sel_o = '0;
    bus.bus_stb_o = 1'b0;
    if (cpu_gnt_q) begin
      bus.bus_adr_o = bus.cpu_adr_i;
      bus.bus_dat_o = bus.cpu_dat_i;
      bus.bus_we_o  = bus.cpu_we_i;
      bus.bus_sel_o = bus.cpu_sel_i;
      bus.bus_stb_o = bus.cpu_stb_i;
    end else if (|dma_gnt_q) begin
      bus.bus_adr_o = bus.dma_adr_i[owner_q*ADR_W +: ADR_W];
      bus.bus_dat_o = bus.dma_dat_i[owner_q*DAT_W +: DAT_W];
      bus.bus_we_o  = bus.dma_we_i[owner_q];
      bus.bus_sel_o = bus.dma_sel_i[owner_q*SEL_W +: SEL_W];
      bus.bus_stb_o = bus.dma_stb_i[owner_q];
    end
  end

  assign bus.bus_cyc_o    = bus.bus_stb_o;
  assign bus.cpu_gnt_o    = cpu_gnt_q;
  assign bus.dma_gnt_o    = dma_gnt_q;
  assign bus.dma_active_o = |dma_gnt_q;
  assign bus.cpu_ack_o    = bus.bus_ack_i & cpu_gnt_q;
  assign bus.dma_ack_o    = {NDMA{bus.bus_ack_i}} & dma_gnt_q;

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Testbench for wb_dma_arbiter: directed ownership scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_wb_dma_arbiter;
  import wb_dma_arbiter_pkg::*;

  localparam int NDMA     = 2;
  localparam int HOLD_MAX = 8;
  localparam int CPU_SLOT = 16;

  localparam int M_CPU    = 0;
  localparam int M_TO_DMA = 1;
  localparam int M_DMA    = 2;
  localparam int M_TO_CPU = 3;

  logic clk_p = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [NDMA-1:0] drv_req = '0;
  logic [NDMA-1:0] drv_stb = '0;
  logic            drv_cpu_stb = 1'b0;
  logic            drv_ack = 1'b0;

  // behavioural model state
  int m_mode;
  int m_owner;
  int m_last;
  int m_owned;
  int m_cpu_cycles;
  bit m_fresh;
  bit m_cpu_xfer;

  int owners[$];
  int gaps[$];
  int tlens[$];

  wb_dma_arbiter_if #(.NDMA(NDMA)) bus_if ();

  wb_dma_arbiter #(.NDMA(NDMA), .HOLD_MAX(HOLD_MAX), .CPU_SLOT(CPU_SLOT)) dut (
    .clk_p (clk_p),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk_p = ~clk_p;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ohIndex(input logic [NDMA-1:0] v);
    for (int i = 0; i < NDMA; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void modelReset();
    m_mode = M_CPU; m_owner = 0; m_last = NDMA - 1; m_owned = 0;
    m_cpu_cycles = 0; m_fresh = 1'b0; m_cpu_xfer = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic modelStep();
    logic [NDMA-1:0] req;
    logic [NDMA-1:0] stb;
    bit slot_open;
    bit found;
    req = bus_if.dma_req_i;
    stb = bus_if.dma_stb_i;
    case (m_mode)
      M_CPU: begin
        slot_open = !m_fresh || m_cpu_xfer || (m_cpu_cycles >= CPU_SLOT - 1);
        if (req != 0 && !bus_if.cpu_stb_i && slot_open) m_mode = M_TO_DMA;
        else begin
          m_cpu_cycles++;
          if (bus_if.cpu_stb_i && bus_if.bus_ack_i) m_cpu_xfer = 1'b1;
        end
      end
      M_TO_DMA: begin
        found = 1'b0;
        for (int k = 1; k <= NDMA; k++) begin
          if (!found && req[(m_last + k) % NDMA]) begin
            found = 1'b1;
            m_owner = (m_last + k) % NDMA;
          end
        end
        if (found) begin m_last = m_owner; m_owned = 1; m_mode = M_DMA; end
        else m_mode = M_CPU;
      end
      M_DMA: begin
        if (!stb[m_owner] && (!req[m_owner] || m_owned >= HOLD_MAX)) m_mode = M_TO_CPU;
        else m_owned++;
      end
      default: begin
        m_mode = M_CPU; m_fresh = 1'b1; m_cpu_cycles = 0; m_cpu_xfer = 1'b0;
      end
    endcase
  endtask

  task automatic checkCycle();
    logic [NDMA-1:0]  exp_gnt;
    logic [ADR_W-1:0] exp_adr;
    logic [DAT_W-1:0] exp_dat;
    logic [SEL_W-1:0] exp_sel;
    logic             exp_we;
    logic             exp_stb;
    exp_gnt = '0;
    exp_adr = '0; exp_dat = '0; exp_sel = '0; exp_we = 1'b0; exp_stb = 1'b0;
    if (m_mode == M_DMA) exp_gnt[m_owner] = 1'b1;
    if (m_mode == M_CPU) begin
      exp_adr = bus_if.cpu_adr_i; exp_dat = bus_if.cpu_dat_i; exp_we = bus_if.cpu_we_i;
      exp_sel = bus_if.cpu_sel_i; exp_stb = bus_if.cpu_stb_i;
    end else if (m_mode == M_DMA) begin
      exp_adr = ADR_W'(bus_if.dma_adr_i >> (ADR_W * m_owner));
      exp_dat = DAT_W'(bus_if.dma_dat_i >> (DAT_W * m_owner));
      exp_sel = SEL_W'(bus_if.dma_sel_i >> (SEL_W * m_owner));
      exp_we  = bus_if.dma_we_i[m_owner];
      exp_stb = bus_if.dma_stb_i[m_owner];
    end
    checkOutput("cpu_gnt",    bus_if.cpu_gnt_o,    (m_mode == M_CPU));
    checkOutput("dma_gnt",    bus_if.dma_gnt_o,    exp_gnt);
    checkOutput("dma_active", bus_if.dma_active_o, (m_mode == M_DMA));
    checkOutput("bus_adr",    bus_if.bus_adr_o,    exp_adr);
    checkOutput("bus_dat",    bus_if.bus_dat_o,    exp_dat);
    checkOutput("bus_we",     bus_if.bus_we_o,     exp_we);
    checkOutput("bus_sel",    bus_if.bus_sel_o,    exp_sel);
    checkOutput("bus_stb",    bus_if.bus_stb_o,    exp_stb);
    checkOutput("bus_cyc",    bus_if.bus_cyc_o,    exp_stb);
    checkOutput("cpu_ack",    bus_if.cpu_ack_o,    (m_mode == M_CPU) && bus_if.bus_ack_i);
    checkOutput("dma_ack",    bus_if.dma_ack_o,    bus_if.bus_ack_i ? exp_gnt : '0);
  endtask

  // Drive control knobs plus fresh random payload onto the inputs
  task automatic applyStimulus();
    bus_if.dma_req_i = drv_req;
    bus_if.dma_stb_i = drv_stb;
    bus_if.cpu_stb_i = drv_cpu_stb;
    bus_if.bus_ack_i = drv_ack;
    bus_if.cpu_adr_i = ADR_W'($urandom);
    bus_if.cpu_dat_i = DAT_W'($urandom);
    bus_if.cpu_we_i  = 1'($urandom);
    bus_if.cpu_sel_i = SEL_W'($urandom);
    for (int i = 0; i < NDMA; i++) begin
      bus_if.dma_adr_i[i*ADR_W +: ADR_W] = ADR_W'($urandom);
      bus_if.dma_dat_i[i*DAT_W +: DAT_W] = DAT_W'($urandom);
      bus_if.dma_sel_i[i*SEL_W +: SEL_W] = SEL_W'($urandom);
    end
    bus_if.dma_we_i = NDMA'($urandom);
  endtask

  task automatic finishCycle();
    @(posedge clk_p);
    modelStep();
    @(negedge clk_p);
  endtask

  task automatic cycle();
    applyStimulus();
    #1;
    checkCycle();
    finishCycle();
  endtask

  task automatic doReset();
    drv_req = '0; drv_stb = '0; drv_cpu_stb = 1'b0; drv_ack = 1'b0;
    applyStimulus();
    rst_n = 1'b0;
    #1;
    modelReset();
    @(negedge clk_p);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int len;
    int exp_len;
    logic [NDMA-1:0] g;
    logic [NDMA-1:0] prev_g;
    logic c;
    logic prev_c;
    int run;
    int tl;
    bit done;

    modelReset();
    applyStimulus();
    @(negedge clk_p);
    @(negedge clk_p);
    rst_n = 1'b1;

    // reset state: processor owns the bus and its strobe/ack pass straight through
    drv_cpu_stb = 1'b1; drv_ack = 1'b1;
    applyStimulus();
    #1;
    checkOutput("rst_cpu_gnt", bus_if.cpu_gnt_o, 1);
    checkOutput("rst_dma_gnt", bus_if.dma_gnt_o, 0);
    checkOutput("rst_bus_stb", bus_if.bus_stb_o, 1);
    checkOutput("rst_cpu_ack", bus_if.cpu_ack_o, 1);
    checkCycle();
    finishCycle();

    // request arrives mid processor transaction: no handover until strobe drops
    drv_req = 2'b01; drv_cpu_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_ack = (i == 2);
      applyStimulus();
      #1;
      checkCycle();
      checkOutput("cpu_keeps_bus", bus_if.cpu_gnt_o, 1);
      finishCycle();
    end
    drv_cpu_stb = 1'b0; drv_ack = 1'b0;
    n = 0;
    while (bus_if.dma_gnt_o != 2'b01 && n < 10) begin
      cycle();
      n++;
    end
    checkOutput("gnt_latency", n, 2);

    // processor strobes while master 0 owns the bus: it never reaches the bus
    drv_cpu_stb = 1'b1; drv_stb = 2'b01; drv_ack = 1'b1;
    applyStimulus();
    #1;
    checkCycle();
    checkOutput("cpu_ack_blocked", bus_if.cpu_ack_o, 0);
    checkOutput("bus_adr_dma0", bus_if.bus_adr_o, bus_if.dma_adr_i[15:0]);
    checkOutput("bus_stb_dma0", bus_if.bus_stb_o, 1);
    finishCycle();
    drv_stb = 2'b00;
    applyStimulus();
    #1;
    checkCycle();
    checkOutput("bus_stb_no_cpu", bus_if.bus_stb_o, 0);
    finishCycle();
    drv_req = '0; drv_cpu_stb = 1'b0; drv_ack = 1'b0;
    repeat (4) cycle();

    // both masters hold requests with an idle processor: rotation and slots
    doReset();
    drv_req = 2'b11;
    owners.delete(); gaps.delete(); tlens.delete();
    prev_g = '0; prev_c = 1'b1; run = 0; tl = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      g = bus_if.dma_gnt_o;
      c = bus_if.cpu_gnt_o;
      if (g != 0) begin
        if (prev_g == 0) begin owners.push_back(ohIndex(g)); tl = 0; end
        tl++;
      end else if (prev_g != 0) tlens.push_back(tl);
      if (c) run++;
      else begin
        if (prev_c && owners.size() > 0) gaps.push_back(run);
        run = 0;
      end
      prev_g = g; prev_c = c;
      done = (owners.size() >= 3 && gaps.size() >= 2);
      if (!done) cycle();
    end
    checkOutput("order_done", done, 1);
    checkOutput("order_first",  owners[0], 0);
    checkOutput("order_second", owners[1], 1);
    checkOutput("order_third",  owners[2], 0);
    checkOutput("slot_gap_1", gaps[0], CPU_SLOT);
    checkOutput("slot_gap_2", gaps[1], CPU_SLOT);
    checkOutput("tenure_len_1", tlens[0], HOLD_MAX);
    checkOutput("tenure_len_2", tlens[1], HOLD_MAX);

    // hold limit with strobe pulses: the tenure ends at the first idle strobe past the limit
    doReset();
    drv_req = 2'b01;
    n = 0; len = -1;
    for (int cyc = 0; cyc < 100 && len < 0; cyc++) begin
      g = bus_if.dma_gnt_o;
      if (g[0]) begin
        n++;
        drv_stb[0] = (n % 3 != 0);
      end else begin
        if (n > 0) len = n;
        drv_stb[0] = 1'b0;
      end
      cycle();
    end
    exp_len = -1;
    for (int k = HOLD_MAX; k < HOLD_MAX + 3; k++) if (exp_len < 0 && k % 3 == 0) exp_len = k;
    checkOutput("hold_len", len, exp_len);

    // reset during a master 1 write strobe withdraws the grant at once
    doReset();
    drv_req = 2'b10;
    n = 0;
    while (bus_if.dma_gnt_o != 2'b10 && n < 20) begin
      cycle();
      n++;
    end
    checkOutput("m1_granted", bus_if.dma_gnt_o, 2'b10);
    drv_stb = 2'b10; drv_ack = 1'b1;
    applyStimulus();
    bus_if.dma_we_i[1] = 1'b1;
    #1;
    checkCycle();
    @(posedge clk_p);
    modelStep();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_dma_gnt", bus_if.dma_gnt_o, 0);
    checkOutput("rst_mid_cpu_gnt", bus_if.cpu_gnt_o, 1);
    checkOutput("rst_mid_dma_ack", bus_if.dma_ack_o, 0);
    checkOutput("rst_mid_active",  bus_if.dma_active_o, 0);
    checkOutput("rst_mid_bus_stb", bus_if.bus_stb_o, 0);
    @(negedge clk_p);
    modelReset();
    drv_req = 2'b11; drv_stb = '0; drv_ack = 1'b0; drv_cpu_stb = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (bus_if.dma_gnt_o == 0 && n < 20) begin
      cycle();
      n++;
    end
    checkOutput("first_after_rst", bus_if.dma_gnt_o, 2'b01);

    // randomized traffic against the model
    doReset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int i = 0; i < NDMA; i++) begin
        if (!drv_req[i]) drv_req[i] = ($urandom_range(3) == 0);
        else if (!drv_stb[i] && $urandom_range(15) == 0) drv_req[i] = 1'b0;
        drv_stb[i] = drv_req[i] && ($urandom_range(1) == 1);
      end
      drv_cpu_stb = ($urandom_range(2) == 0);
      drv_ack     = ($urandom_range(1) == 1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
